// File: rtl/eth_pkg.sv
// Shared Ethernet types: OutFIFO status/command structs, pointer and length types,
// and the TX launch scheduler state enum.
package eth_pkg;

   localparam int ETH_OUTFIFO_KB_SIZE = 2;
   localparam int ETH_TX_DESC_SLOTS   = 4;

   typedef logic [15:0] ptr_t;
   typedef logic [15:0] udp_length_t;

   typedef struct packed {
      ptr_t rd_ptr;
      ptr_t wr_ptr;
      logic empty;
      logic full;
      logic done;
   } s_fifo_st_t;

   typedef struct packed {
      logic        clear;
      logic        start;
      udp_length_t length;
   } s_fifo_cmd_t;

   typedef enum logic [2:0] {
      IDLE_TXS_ST      = 3'd0,
      WAIT_DATA_TXS_ST = 3'd1,
      STREAM_TXS_ST    = 3'd2,
      RELEASE_TXS_ST   = 3'd3,
      CLEAR_TXS_ST     = 3'd4
   } tx_sched_st_t;

endpackage

// File: rtl/eth_fifo.sv
// Small synchronous FIFO with first-word-fall-through head and a synchronous flush.
// Push is ignored when full, pop is ignored when empty.
module eth_fifo #(
   parameter int SLOTS = 4,
   parameter int WIDTH = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head,
   output logic             o_empty,
   output logic             o_full
);

   localparam int AW = $clog2(SLOTS);

   logic [WIDTH-1:0] r_mem [SLOTS];
   logic [AW:0]      r_wr;
   logic [AW:0]      r_rd;
   logic             w_do_push;
   logic             w_do_pop;

   assign w_do_push = i_push & ~o_full;
   assign w_do_pop  = i_pop & ~o_empty;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         r_wr <= '0;
         r_rd <= '0;
      end else begin
         if (w_do_push) r_wr <= r_wr + 1'b1;
         if (w_do_pop)  r_rd <= r_rd + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_data;
   end

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign o_empty = (r_wr == r_rd);
   assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
   assign o_head  = r_mem[r_rd[AW-1:0]];

endmodule

// File: rtl/eth_tx_sched.sv
// OutFIFO packet launch scheduler: queues length descriptors, starts a packet once enough
// bytes are resident, sequences FIFO clears. Optional WAIT_DATA watchdog: ETH_TX_SCHED_WDT_EN.
import eth_pkg::*;

module eth_tx_sched #(
   parameter int DESC_SLOTS = ETH_TX_DESC_SLOTS,
   parameter int FIFO_BYTES = ETH_OUTFIFO_KB_SIZE * 1024,
   parameter int WDT_CYCLES = 65535
) (
   input  logic         clk_eth,
   input  logic         rst_eth,
   input  logic         desc_valid_i,
   input  udp_length_t  desc_len_i,
   output logic         desc_ready_o,
   input  logic         clear_req_i,
   input  s_fifo_st_t   fifo_st_i,
   output s_fifo_cmd_t  fifo_cmd_o,
   output logic         busy_o,
   output logic [15:0]  sent_cnt_o,
   output logic [15:0]  drop_cnt_o,
   output logic         err_o,
   output tx_sched_st_t dbg_state_o
);

   tx_sched_st_t r_state;
   tx_sched_st_t w_nxt;
   udp_length_t  r_len;
   logic         r_clear_pend;
   logic [15:0]  r_sent;
   logic [15:0]  r_drop;
   udp_length_t  w_head;
   ptr_t         w_occ;
   logic         w_q_empty, w_q_full, w_push, w_pop, w_flush;
   logic         w_drop, w_sent, w_load_len, w_len_bad, w_wdt_trip;
   logic         w_unused_st;

   // Descriptor handshake: a transfer happens on a cycle where desc_valid_i && desc_ready_o;
   // ready depends only on registered state, never on desc_valid_i.
   assign desc_ready_o = ~w_q_full & (r_state != CLEAR_TXS_ST);
   assign w_push       = desc_valid_i & desc_ready_o;

   eth_fifo #(
      .SLOTS (DESC_SLOTS),
      .WIDTH ($bits(udp_length_t))
   ) u_desc_q (
      .i_clk   (clk_eth),
      .i_rst   (rst_eth),
      .i_flush (w_flush),
      .i_push  (w_push),
      .i_data  (desc_len_i),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_empty (w_q_empty),
      .o_full  (w_q_full)
   );

   // Modular subtraction keeps occupancy right across pointer wrap.
   assign w_occ       = fifo_st_i.wr_ptr - fifo_st_i.rd_ptr;
   assign w_len_bad   = (w_head == '0) || (32'(w_head) > 32'(FIFO_BYTES));
   assign w_unused_st = fifo_st_i.empty ^ fifo_st_i.full;

`ifdef ETH_TX_SCHED_WDT_EN
   logic [15:0] r_wdt;

   always_ff @(posedge clk_eth) begin
      if (rst_eth || r_state != WAIT_DATA_TXS_ST) r_wdt <= '0;
      else                                       r_wdt <= r_wdt + 16'd1;
   end

   assign w_wdt_trip = (r_state == WAIT_DATA_TXS_ST) && !r_clear_pend &&
                       (w_occ < r_len) && (r_wdt == 16'(WDT_CYCLES - 1));
`else
   assign w_wdt_trip = 1'b0;
`endif

   always_comb begin
      w_nxt      = r_state;
      w_pop      = 1'b0;
      w_drop     = 1'b0;
      w_sent     = 1'b0;
      w_load_len = 1'b0;
      w_flush    = 1'b0;
      case (r_state)
         IDLE_TXS_ST: begin
            if (r_clear_pend) begin
               w_nxt = CLEAR_TXS_ST;
            end else if (!w_q_empty) begin
               if (w_len_bad) begin
                  w_pop  = 1'b1;
                  w_drop = 1'b1;
               end else begin
                  w_load_len = 1'b1;
                  w_nxt      = WAIT_DATA_TXS_ST;
               end
            end
         end
         WAIT_DATA_TXS_ST: begin
            if (r_clear_pend)       w_nxt = CLEAR_TXS_ST;
            else if (w_occ >= r_len) w_nxt = STREAM_TXS_ST;
            else if (w_wdt_trip) begin
               w_pop  = 1'b1;
               w_drop = 1'b1;
               w_nxt  = CLEAR_TXS_ST;
            end
         end
         STREAM_TXS_ST: begin
            if (fifo_st_i.done) begin
               w_pop  = 1'b1;
               w_sent = 1'b1;
               w_nxt  = RELEASE_TXS_ST;
            end
         end
         RELEASE_TXS_ST: w_nxt = r_clear_pend ? CLEAR_TXS_ST : IDLE_TXS_ST;
         CLEAR_TXS_ST: begin
            w_flush = 1'b1;
            w_nxt   = IDLE_TXS_ST;
         end
         default: w_nxt = IDLE_TXS_ST;
      endcase
   end

   always_ff @(posedge clk_eth) begin
      if (rst_eth) begin
         r_state      <= IDLE_TXS_ST;
         r_len        <= '0;
         r_clear_pend <= 1'b0;
         r_sent       <= '0;
         r_drop       <= '0;
      end else begin
         r_state <= w_nxt;
         if (w_load_len) r_len <= w_head;
         // A clear request is only acted on outside STREAM; holding it here defers it.
         if (r_state == CLEAR_TXS_ST)         r_clear_pend <= 1'b0;
         else if (clear_req_i || w_wdt_trip) r_clear_pend <= 1'b1;
         if (w_sent) r_sent <= r_sent + 16'd1;
         if (w_drop) r_drop <= r_drop + 16'd1;
      end
   end

   assign fifo_cmd_o.clear  = (r_state == CLEAR_TXS_ST);
   assign fifo_cmd_o.start  = (r_state == STREAM_TXS_ST);
   assign fifo_cmd_o.length = r_len;
   assign busy_o            = (r_state != IDLE_TXS_ST) | ~w_q_empty;
   assign sent_cnt_o        = r_sent;
   assign drop_cnt_o        = r_drop;
   assign err_o             = w_drop;
   assign dbg_state_o       = r_state;

endmodule

// File: tb/tb_eth_tx_sched.sv
// Self-checking bench for eth_tx_sched: OutFIFO emulator, descriptor scoreboard,
// table-driven length vectors, hand sequences for clear/wrap/reset, randomized traffic.
module tb_eth_tx_sched;
   import eth_pkg::*;

   localparam int FIFO_BYTES = ETH_OUTFIFO_KB_SIZE * 1024;

   logic         clk_eth = 1'b0;
   logic         rst_eth;
   logic         desc_valid_i;
   udp_length_t  desc_len_i;
   logic         desc_ready_o;
   logic         clear_req_i;
   s_fifo_st_t   fifo_st_i;
   s_fifo_cmd_t  fifo_cmd_o;
   logic         busy_o;
   logic [15:0]  sent_cnt_o;
   logic [15:0]  drop_cnt_o;
   logic         err_o;
   tx_sched_st_t dbg_state_o;

   ptr_t wr_ptr = '0;
   ptr_t rd_ptr = '0;
   logic done   = 1'b0;

   assign fifo_st_i = {rd_ptr, wr_ptr, (wr_ptr == rd_ptr), 1'b0, done};

   eth_tx_sched #(.WDT_CYCLES(100)) dut (
      .clk_eth      (clk_eth),
      .rst_eth      (rst_eth),
      .desc_valid_i (desc_valid_i),
      .desc_len_i   (desc_len_i),
      .desc_ready_o (desc_ready_o),
      .clear_req_i  (clear_req_i),
      .fifo_st_i    (fifo_st_i),
      .fifo_cmd_o   (fifo_cmd_o),
      .busy_o       (busy_o),
      .sent_cnt_o   (sent_cnt_o),
      .drop_cnt_o   (drop_cnt_o),
      .err_o        (err_o),
      .dbg_state_o  (dbg_state_o)
   );

   always #5 clk_eth = ~clk_eth;

   int n_checks = 0;
   int n_errors = 0;

   // Scoreboard: lengths expected to be launched, in order.
   logic [15:0] exp_q[$];
   int exp_sent = 0;
   int exp_drops = 0;
   int err_seen = 0;
   int clears_seen = 0;

   // Emulator state.
   bit          auto_fill = 1'b0;
   int          pending = 0;
   bit          in_stream = 1'b0;
   bit          prev_start = 1'b0;
   bit          prev_clear = 1'b0;
   bit          expect_release = 1'b0;
   int          stream_timer = 0;
   int          cyc = 0;
   int          done_cycle = -1;
   int          clear_cycle = -1;
   logic [15:0] last_occ = '0;
   logic [15:0] cur_len = '0;

   typedef struct {
      int len;
      bit is_drop;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_eth);
      #1;
   endtask

   task automatic push_desc(input int len, input bit fill);
      int guard;
      guard = 0;
      desc_len_i   = 16'(len);
      desc_valid_i = 1'b1;
      while (!desc_ready_o && guard < 2000) begin
         tick();
         guard++;
      end
      check("push_ready", 32'(desc_ready_o), 1);
      if (len == 0 || len > FIFO_BYTES) begin
         exp_drops++;
      end else begin
         exp_q.push_back(16'(len));
         exp_sent++;
         if (fill) pending += len;
      end
      tick();
      desc_valid_i = 1'b0;
   endtask

   task automatic wait_idle(input int max);
      int n;
      n = 0;
      while (busy_o && n < max) begin
         tick();
         n++;
      end
      check("idle_reached", 32'(busy_o), 0);
   endtask

   task automatic wait_start(input int max);
      int n;
      n = 0;
      while (!fifo_cmd_o.start && n < max) begin
         tick();
         n++;
      end
      check("start_seen", 32'(fifo_cmd_o.start), 1);
   endtask

   // OutFIFO emulator: fills bytes, answers start with a done pulse after a few cycles,
   // and checks launch rules on every start edge.
   initial begin
      int k;
      forever begin
         @(posedge clk_eth);
         #2;
         cyc++;
         if (rst_eth) begin
            done = 1'b0;
            in_stream = 1'b0;
            prev_start = 1'b0;
            prev_clear = 1'b0;
            expect_release = 1'b0;
            done_cycle = -1;
            last_occ = wr_ptr - rd_ptr;
            continue;
         end
         done = 1'b0;
         if (expect_release) begin
            check("start_drop_after_done", 32'(fifo_cmd_o.start), 0);
            expect_release = 1'b0;
         end
         if (fifo_cmd_o.start && !prev_start) begin
            check("start_queued", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               cur_len = exp_q.pop_front();
               check("start_len", 32'(fifo_cmd_o.length), 32'(cur_len));
            end else begin
               cur_len = fifo_cmd_o.length;
            end
            check("start_occ_ok", 32'(last_occ >= fifo_cmd_o.length), 1);
            if (done_cycle >= 0) check("start_gap_ge3", 32'((cyc - done_cycle) >= 3), 1);
            in_stream = 1'b1;
            stream_timer = $urandom_range(2, 5);
         end else if (in_stream) begin
            check("start_held", 32'(fifo_cmd_o.start), 1);
            check("len_stable", 32'(fifo_cmd_o.length), 32'(cur_len));
            stream_timer--;
            if (stream_timer == 0) begin
               done = 1'b1;
               rd_ptr = rd_ptr + cur_len;
               in_stream = 1'b0;
               done_cycle = cyc;
               expect_release = 1'b1;
            end
         end
         if (fifo_cmd_o.clear) begin
            clears_seen++;
            clear_cycle = cyc;
            check("clear_one_cycle", 32'(prev_clear), 0);
            check("clear_no_start", 32'(fifo_cmd_o.start), 0);
            rd_ptr = wr_ptr;
            pending = 0;
         end
         if (err_o) err_seen++;
         prev_clear = fifo_cmd_o.clear;
         prev_start = fifo_cmd_o.start;
         if (auto_fill && pending > 0) begin
            k = $urandom_range(1, 64);
            if (k > pending) k = pending;
            wr_ptr = wr_ptr + 16'(k);
            pending -= k;
         end
         last_occ = wr_ptr - rd_ptr;
      end
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      vec_t vecs[6];
      int   c0;
      int   d0;
      vecs[0] = '{len: 0,              is_drop: 1'b1};
      vecs[1] = '{len: FIFO_BYTES + 1, is_drop: 1'b1};
      vecs[2] = '{len: 10,             is_drop: 1'b0};
      vecs[3] = '{len: FIFO_BYTES,     is_drop: 1'b0};
      vecs[4] = '{len: 1,              is_drop: 1'b0};
      vecs[5] = '{len: 65535,          is_drop: 1'b1};

      rst_eth = 1'b1;
      desc_valid_i = 1'b0;
      desc_len_i = '0;
      clear_req_i = 1'b0;
      repeat (3) @(posedge clk_eth);
      #1;
      rst_eth = 1'b0;
      tick();
      check("rst_cmd", 32'(fifo_cmd_o), 0);
      check("rst_sent", 32'(sent_cnt_o), 0);
      check("rst_drop", 32'(drop_cnt_o), 0);
      check("rst_err", 32'(err_o), 0);
      check("rst_busy", 32'(busy_o), 0);
      check("rst_ready", 32'(desc_ready_o), 1);
      check("rst_state", 32'(dbg_state_o), 32'(IDLE_TXS_ST));

      // Occupancy ramps by 4 per cycle; start must rise exactly once 64 is visible.
      auto_fill = 1'b0;
      push_desc(64, 1'b0);
      for (int i = 0; i < 16; i++) begin
         check("t1_no_early_start", 32'(fifo_cmd_o.start), 0);
         wr_ptr = wr_ptr + 16'd4;
         tick();
      end
      check("t1_start_rise", 32'(fifo_cmd_o.start), 1);
      check("t1_len", 32'(fifo_cmd_o.length), 64);
      wait_idle(200);
      check("t1_sent", 32'(sent_cnt_o), 1);

      // Length table: invalid lengths are dropped with an error pulse, valid ones launch.
      auto_fill = 1'b1;
      for (int i = 0; i < 6; i++) begin
         d0 = err_seen;
         push_desc(vecs[i].len, 1'b1);
         wait_idle(500);
         check("vec_sent", 32'(sent_cnt_o), 32'(exp_sent));
         check("vec_drop", 32'(drop_cnt_o), 32'(exp_drops));
         check("vec_err_pulses", 32'(err_seen - d0), 32'(vecs[i].is_drop));
      end

      // Four back-to-back descriptors with no data yet: queue fills, then all launch in order.
      auto_fill = 1'b0;
      rd_ptr = wr_ptr;
      push_desc(10, 1'b1);
      push_desc(20, 1'b1);
      push_desc(30, 1'b1);
      push_desc(40, 1'b1);
      check("t3_ready_low_full", 32'(desc_ready_o), 0);
      check("t3_no_start_yet", 32'(fifo_cmd_o.start), 0);
      auto_fill = 1'b1;
      wait_idle(1000);
      check("t3_sent", 32'(sent_cnt_o), 32'(exp_sent));

      // Pointer wrap: 7 bytes resident must not launch len 8, 8 bytes must.
      auto_fill = 1'b0;
      rd_ptr = 16'hFFFA;
      wr_ptr = 16'h0001;
      push_desc(8, 1'b0);
      repeat (10) tick();
      check("t4_no_start_occ7", 32'(fifo_cmd_o.start), 0);
      check("t4_busy_waiting", 32'(busy_o), 1);
      wr_ptr = 16'h0002;
      wait_idle(100);
      check("t4_sent", 32'(sent_cnt_o), 32'(exp_sent));

      // Clear requested mid-stream: packet finishes, then a single clear flushes the rest.
      auto_fill = 1'b1;
      push_desc(16, 1'b1);
      push_desc(16, 1'b1);
      push_desc(16, 1'b1);
      wait_start(500);
      c0 = clears_seen;
      d0 = exp_drops;
      clear_req_i = 1'b1;
      tick();
      clear_req_i = 1'b0;
      exp_sent -= exp_q.size();
      exp_q.delete();
      wait_idle(200);
      check("t5_one_clear", 32'(clears_seen - c0), 1);
      check("t5_clear_after_release", 32'(clear_cycle - done_cycle), 2);
      check("t5_sent", 32'(sent_cnt_o), 32'(exp_sent));
      check("t5_no_drops", 32'(drop_cnt_o), 32'(d0));

`ifdef ETH_TX_SCHED_WDT_EN
      begin
         int n;
         auto_fill = 1'b0;
         rd_ptr = wr_ptr;
         push_desc(50, 1'b0);
         wr_ptr = wr_ptr + 16'd20;
         n = 0;
         while (!err_o && n < 300) begin
            tick();
            n++;
         end
         check("t6_err_pulse", 32'(err_o), 1);
         check("t6_wdt_cycles", 32'(n), 100);
         void'(exp_q.pop_back());
         exp_sent--;
         exp_drops++;
         tick();
         check("t6_clear", 32'(fifo_cmd_o.clear), 1);
         check("t6_drop", 32'(drop_cnt_o), 32'(exp_drops));
         wait_idle(50);
      end
`endif

      // Randomized traffic including zero and oversize lengths.
      auto_fill = 1'b1;
      for (int i = 0; i < 40; i++) begin
         int r;
         int len;
         r = $urandom_range(0, 15);
         if (r == 0)      len = 0;
         else if (r == 1) len = $urandom_range(FIFO_BYTES + 1, 65535);
         else             len = $urandom_range(1, 300);
         push_desc(len, 1'b1);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 20)) tick();
      end
      wait_idle(30000);
      check("rnd_sent", 32'(sent_cnt_o), 32'(exp_sent));
      check("rnd_drop", 32'(drop_cnt_o), 32'(exp_drops));
      check("rnd_err_pulses", 32'(err_seen), 32'(exp_drops));
      check("rnd_queue_drained", 32'(exp_q.size()), 0);

      // Reset while streaming returns everything to reset values.
      push_desc(32, 1'b1);
      wait_start(500);
      rst_eth = 1'b1;
      tick();
      tick();
      rst_eth = 1'b0;
      exp_q.delete();
      exp_sent = 0;
      exp_drops = 0;
      err_seen = 0;
      pending = 0;
      rd_ptr = wr_ptr;
      tick();
      check("rst2_cmd", 32'(fifo_cmd_o), 0);
      check("rst2_sent", 32'(sent_cnt_o), 0);
      check("rst2_drop", 32'(drop_cnt_o), 0);
      check("rst2_busy", 32'(busy_o), 0);
      check("rst2_ready", 32'(desc_ready_o), 1);
      push_desc(24, 1'b1);
      wait_idle(300);
      check("rst2_sent_after", 32'(sent_cnt_o), 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
